// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out stream serialiser.
package piso_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } piso_state_e;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter that saturates at zero and flags its final count.
module bit_down_counter #(
    parameter int unsigned MaxCount = 8,
    parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            is_last_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(MaxCount);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o   = cnt_q;
    assign is_last_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/piso_stream.sv
// Serialises WIDTH-bit words onto a registered bit stream with a last-bit done pulse.
module piso_stream
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b0,
    parameter bit          IDLE_BIT  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    piso_state_e     state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic            ser_out_q, ser_out_d;
    logic            done_q, done_d;
    logic            accept;
    logic            cnt_load, cnt_dec, cnt_last;
    logic [CntW-1:0] cnt;

    function automatic logic out_bit(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? d[WIDTH-1] : d[0];
    endfunction

    // Move the word one place toward the output end, backfilling with IDLE_BIT.
    function automatic logic [WIDTH-1:0] shift_fill(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r    = d << 1;
            r[0] = IDLE_BIT;
        end else begin
            r          = d >> 1;
            r[WIDTH-1] = IDLE_BIT;
        end
        return r;
    endfunction

    bit_down_counter #(
        .MaxCount (WIDTH),
        .CntW     (CntW)
    ) u_bit_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (cnt_load),
        .dec_i     (cnt_dec),
        .count_o   (cnt),
        .is_last_o (cnt_last)
    );

    assign in_ready_o = !rst_i && ((state_q == StIdle) || cnt_last);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        ser_out_d = ser_out_q;
        done_d    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        if (accept) begin
            // The first bit goes straight to the output register, so only
            // the remaining bits stay in the shift register.
            state_d   = StShift;
            shift_d   = shift_fill(in_data_i);
            ser_out_d = out_bit(in_data_i);
            done_d    = (WIDTH == 1);
            cnt_load  = 1'b1;
        end else if (state_q == StShift) begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
                state_d   = StIdle;
                ser_out_d = IDLE_BIT;
            end else begin
                shift_d   = shift_fill(shift_q);
                ser_out_d = out_bit(shift_q);
                done_d    = (cnt == CntW'(2));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            shift_q   <= {WIDTH{IDLE_BIT}};
            ser_out_q <= IDLE_BIT;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            ser_out_q <= ser_out_d;
            done_q    <= done_d;
        end
    end

    assign ser_out_o   = ser_out_q;
    assign ser_valid_o = (state_q == StShift);
    assign busy_o      = (state_q == StShift);
    assign done_o      = done_q;

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench: LSB-first, MSB-first and single-bit instances of piso_stream.
module tb_piso_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       va, vb, vc;
    logic [7:0] da, db;
    logic [0:0] dc;
    logic       ra, soa, sva, dna, bsa;
    logic       rb, sob, svb, dnb, bsb;
    logic       rc, soc, svc, dnc, bsc;

    int n_tests = 0;
    int n_fail  = 0;

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk_i(clk), .rst_i(rst), .in_valid_i(va), .in_ready_o(ra), .in_data_i(da),
        .ser_out_o(soa), .ser_valid_o(sva), .done_o(dna), .busy_o(bsa)
    );

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
        .clk_i(clk), .rst_i(rst), .in_valid_i(vb), .in_ready_o(rb), .in_data_i(db),
        .ser_out_o(sob), .ser_valid_o(svb), .done_o(dnb), .busy_o(bsb)
    );

    piso_stream #(.WIDTH(1), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_w1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(vc), .in_ready_o(rc), .in_data_i(dc),
        .ser_out_o(soc), .ser_valid_o(svc), .done_o(dnc), .busy_o(bsc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        va = 1'b1; da = 8'hFF; vb = 1'b1; db = 8'hFF; vc = 1'b1; dc = 1'b1;
        step();
        step();
        n_tests++;
        if ({sva, soa, dna, bsa, ra} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_lsb: valid/out/done/busy/ready=%b want 01000",
                     {sva, soa, dna, bsa, ra});
        end
        n_tests++;
        if ({svb, sob, dnb, bsb, rb} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_msb: valid/out/done/busy/ready=%b want 01000",
                     {svb, sob, dnb, bsb, rb});
        end
        n_tests++;
        if ({svc, soc, dnc, bsc, rc} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_w1: valid/out/done/busy/ready=%b want 01000",
                     {svc, soc, dnc, bsc, rc});
        end
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({ra, rb, rc} !== 3'b111) begin
            n_fail++;
            $display("FAIL ready_after_reset: ready=%b want 111", {ra, rb, rc});
        end
    endtask

    task automatic test_lsb_first();
        logic [0:7] want;
        want = 8'b0110_1001;
        va = 1'b1; da = 8'h96;
        step();
        va = 1'b0; da = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (soa !== want[i] || sva !== 1'b1 || bsa !== 1'b1 || dna !== (i == 7) ||
                ra !== (i == 7)) begin
                n_fail++;
                $display("FAIL lsb_bit%0d: out=%b valid=%b busy=%b done=%b ready=%b, want %b 1 1 %b %b",
                         i, soa, sva, bsa, dna, ra, want[i], (i == 7), (i == 7));
            end
            step();
        end
        n_tests++;
        if ({sva, soa, dna} !== 3'b010) begin
            n_fail++;
            $display("FAIL lsb_idle: valid/out/done=%b want 010", {sva, soa, dna});
        end
    endtask

    task automatic test_msb_first();
        logic [0:7] want;
        want = 8'b1001_0110;
        vb = 1'b1; db = 8'h96;
        step();
        vb = 1'b0; db = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (sob !== want[i] || svb !== 1'b1 || dnb !== (i == 7)) begin
                n_fail++;
                $display("FAIL msb_bit%0d: out=%b valid=%b done=%b, want %b 1 %b",
                         i, sob, svb, dnb, want[i], (i == 7));
            end
            step();
        end
        n_tests++;
        if ({svb, sob, dnb} !== 3'b010) begin
            n_fail++;
            $display("FAIL msb_idle: valid/out/done=%b want 010", {svb, sob, dnb});
        end
    endtask

    task automatic test_back_to_back();
        logic [0:15] want;
        want = 16'b0110_1001_1111_0000;
        va = 1'b1; da = 8'h96;
        step();
        da = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (soa !== want[i] || sva !== 1'b1 || dna !== (i == 7 || i == 15) ||
                ra !== (i == 7 || i == 15)) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: out=%b valid=%b done=%b ready=%b, want %b 1 %b %b",
                         i, soa, sva, dna, ra, want[i], (i == 7 || i == 15),
                         (i == 7 || i == 15));
            end
            step();
            if (i == 7) va = 1'b0;
        end
        n_tests++;
        if ({sva, soa, dna} !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_idle: valid/out/done=%b want 010", {sva, soa, dna});
        end
    endtask

    task automatic test_hold_valid();
        logic [0:15] want;
        want = 16'b0000_0000_1111_1111;
        va = 1'b1; da = 8'h00;
        step();
        da = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (soa !== want[i] || sva !== 1'b1 || dna !== (i == 7 || i == 15) ||
                ra !== (i == 7 || i == 15)) begin
                n_fail++;
                $display("FAIL hold_bit%0d: out=%b valid=%b done=%b ready=%b, want %b 1 %b %b",
                         i, soa, sva, dna, ra, want[i], (i == 7 || i == 15),
                         (i == 7 || i == 15));
            end
            step();
            if (i == 7) va = 1'b0;
        end
        n_tests++;
        if ({sva, soa, dna} !== 3'b010) begin
            n_fail++;
            $display("FAIL hold_idle: valid/out/done=%b want 010", {sva, soa, dna});
        end
    endtask

    task automatic test_reset_abort();
        logic [0:7] want;
        want = 8'b0110_1001;
        va = 1'b1; da = 8'h96;
        step();
        va = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (soa !== want[i] || sva !== 1'b1 || dna !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_bit%0d: out=%b valid=%b done=%b, want %b 1 0",
                         i, soa, sva, dna, want[i]);
            end
            if (i < 3) step();
        end
        rst = 1'b1; va = 1'b1; da = 8'hFF;
        #1;
        n_tests++;
        if (ra !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready_in_rst: ready=%b want 0", ra);
        end
        step();
        rst = 1'b0; va = 1'b0; da = 8'h00;
        n_tests++;
        if ({sva, soa, dna, bsa} !== 4'b0100) begin
            n_fail++;
            $display("FAIL abort_after_rst: valid/out/done/busy=%b want 0100",
                     {sva, soa, dna, bsa});
        end
        step();
        n_tests++;
        if ({sva, soa, dna} !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_no_resume: valid/out/done=%b want 010", {sva, soa, dna});
        end
        want = 8'b0101_1010;
        va = 1'b1; da = 8'h5A;
        step();
        va = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (soa !== want[i] || sva !== 1'b1 || dna !== (i == 7)) begin
                n_fail++;
                $display("FAIL post_abort_bit%0d: out=%b valid=%b done=%b, want %b 1 %b",
                         i, soa, sva, dna, want[i], (i == 7));
            end
            step();
        end
    endtask

    task automatic test_width1();
        logic [0:2] want;
        want = 3'b101;
        vc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dc = want[i];
            step();
            n_tests++;
            if ({soc, svc, dnc, rc} !== {want[i], 3'b111}) begin
                n_fail++;
                $display("FAIL w1_bit%0d: out/valid/done/ready=%b want %b111",
                         i, {soc, svc, dnc, rc}, want[i]);
            end
        end
        vc = 1'b0;
        step();
        n_tests++;
        if ({svc, soc, dnc} !== 3'b010) begin
            n_fail++;
            $display("FAIL w1_idle: valid/out/done=%b want 010", {svc, soc, dnc});
        end
    endtask

    initial begin
        rst = 1'b1;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        da = 8'h00; db = 8'h00; dc = 1'b0;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_hold_valid();
        test_reset_abort();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits, legal range 1..64.
REQ-002 Parameter MSB_FIRST, default 0: 0 shifts bit 0 out first, 1 shifts bit WIDTH-1 out first.
REQ-003 Parameter IDLE_BIT, default 1'b1: level driven on ser_out when no frame is active, and the fill bit shifted into vacated positions.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a word offered for serialisation.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  WIDTH  parallel word.
REQ-009 ser_out  output  1  serial data bit, registered.
REQ-010 ser_valid  output  1  ser_out carries a frame bit this cycle, registered.
REQ-011 done  output  1  one-cycle pulse coincident with the last bit of a frame, registered.
REQ-012 busy  output  1  a frame is in progress; equals ser_valid.

Function
REQ-013 State machine SHALL have two states: IDLE and SHIFT.
REQ-014 Accept SHALL occur on a rising edge where in_valid and in_ready are both high; in_data is captured into the shift register and the bit counter is set to WIDTH.
REQ-015 in_ready SHALL be combinational: high in IDLE, and high in SHIFT only when the counter equals 1 (last-bit cycle); low otherwise.
REQ-016 First bit of an accepted word SHALL appear on ser_out with ser_valid=1 in the cycle after acceptance (latency 1).
REQ-017 In SHIFT, each cycle SHALL present one bit, decrement the counter, and shift the register toward the output end, filling the vacated position with IDLE_BIT.
REQ-018 Bit order SHALL be bit 0..WIDTH-1 when MSB_FIRST=0, and WIDTH-1..0 when MSB_FIRST=1.
REQ-019 done SHALL be 1 exactly in the cycle ser_out carries bit WIDTH of the frame, and 0 otherwise.
REQ-020 Acceptance in the last-bit cycle SHALL start the next frame in the following cycle with no gap: ser_valid stays high and the state stays SHIFT.
REQ-021 Without acceptance in the last-bit cycle, the FSM SHALL return to IDLE; the next cycle has ser_valid=0 and ser_out=IDLE_BIT.
REQ-022 in_valid while in_ready=0 SHALL be ignored; in_data is not sampled and the active frame is unaffected.
REQ-023 Counter width SHALL be $clog2(WIDTH+1) bits; it never wraps below 0 and never exceeds WIDTH.
REQ-024 WIDTH=1 SHALL produce single-bit frames with done on every frame bit; back-to-back acceptance yields a continuous stream.

Reset
REQ-025 When rst=1 at a rising edge: state=IDLE, counter=0, shift register all IDLE_BIT, ser_out=IDLE_BIT, ser_valid=0, done=0.
REQ-026 rst SHALL take priority over acceptance and shifting; a frame in progress is aborted with no done pulse, and no word is accepted in a reset cycle.
REQ-027 in_ready SHALL be 0 while rst=1.

Structure
REQ-028 Shared package piso_pkg SHALL hold the state encodings (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH constant.
REQ-029 The bit counter SHALL be a separate sub-module, bit_down_counter (load, decrement, is_last flag), reusable by future serialisers.
REQ-030 The datapath SHALL contain no latches or combinational loops; in_ready depends only on state, counter and rst.

Verification
REQ-031 WIDTH=8, MSB_FIRST=0: accept 0x96 -> ser_out 0,1,1,0,1,0,0,1 on cycles 1..8, done on cycle 8, ser_out=1 on cycle 9.
REQ-032 MSB_FIRST=1: accept 0x96 -> ser_out 1,0,0,1,0,1,1,0, done on bit 8.
REQ-033 Back-to-back: 0x96, then 0x0F offered with in_valid held -> 0x0F accepted on the last-bit cycle, 16 contiguous ser_valid cycles, two done pulses 8 cycles apart.
REQ-034 Hold in_valid=1 with 0xFF during a frame of 0x00 -> the 0x00 frame is unchanged, and 0xFF is accepted only on the last-bit cycle.
REQ-035 Assert rst for one cycle at bit 4 of 0x96 -> next cycle ser_valid=0, ser_out=1, no done; a subsequent 0x5A serialises correctly.
REQ-036 WIDTH=1: in_valid held with data 1,0,1 -> ser_out 1,0,1 contiguous, done high each cycle.
